// File: rtl/fetch_line_buffer.sv
// Instruction-fetch byte window: holds up to two consecutive 64-byte lines and
// presents FETCH_BYTES bytes at the fetch PC, refilling through a line reader.
module fetch_line_buffer #(
  parameter int unsigned FETCH_BYTES = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               redirect_valid,
  input  logic [63:0]                        redirect_pc,
  output logic                               out_valid,
  output logic [63:0]                        out_pc,
  output logic [FETCH_BYTES*8-1:0]           out_bytes,
  input  logic [$clog2(FETCH_BYTES+1)-1:0]   consume,
  output logic                               rd_reqcyc,
  output logic [63:0]                        rd_addr,
  input  logic                               rd_respcyc,
  input  logic [511:0]                       rd_data
);

  localparam int unsigned WB = FETCH_BYTES * 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t        state, state_next;
  logic [63:0]   pc, head, req_addr;
  logic [511:0]  line0, line1;
  logic          v0, v1, started;

  logic [6:0]    off_sum;
  logic          do_pop, fill0, fill1;
  logic [63:0]   head_post, fetch_addr;
  logic          v0_post, v1_post;
  logic [1023:0] window;

  assign off_sum   = 7'(pc[5:0]) + 7'(consume);
  assign out_valid = v0 && (((7'(pc[5:0]) + 7'(FETCH_BYTES)) <= 7'd64) || v1);
  assign out_pc    = pc;
  assign window    = {line0, line1} << {pc[5:0], 3'b000};
  assign out_bytes = out_valid ? WB'(window >> (1024 - WB)) : '0;

  // Pop is resolved first; request and fill decisions look at post-pop state.
  always_comb begin
    do_pop    = 1'b0;
    head_post = head;
    v0_post   = v0;
    v1_post   = v1;
    if (out_valid && !redirect_valid && off_sum >= 7'd64) begin
      do_pop    = 1'b1;
      head_post = head + 64'd64;
      v0_post   = v1;
      v1_post   = 1'b0;
    end
    fetch_addr = v0_post ? head_post + 64'd64 : head_post;

    state_next = state;
    rd_reqcyc  = 1'b0;
    fill0      = 1'b0;
    fill1      = 1'b0;
    case (state)
      S_IDLE: begin
        if (started && !redirect_valid && !(v0_post && v1_post)) begin
          rd_reqcyc  = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rd_respcyc) begin
          state_next = S_IDLE;
          if (!redirect_valid) begin
            fill0 = (req_addr == head_post);
            fill1 = (req_addr == head_post + 64'd64);
          end
        end else if (redirect_valid) begin
          state_next = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (rd_respcyc) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    rd_addr = (state == S_IDLE) ? fetch_addr : req_addr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      started  <= 1'b0;
      pc       <= '0;
      head     <= '0;
      req_addr <= '0;
      line0    <= '0;
      line1    <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
      if (rd_reqcyc) req_addr <= fetch_addr;
      if (redirect_valid) begin
        pc   <= redirect_pc;
        head <= redirect_pc & ~64'h3F;
        v0   <= 1'b0;
        v1   <= 1'b0;
      end else begin
        if (out_valid) pc <= pc + 64'(consume);
        head <= head_post;
        v0   <= v0_post || fill0;
        v1   <= v1_post || fill1;
        if (fill0)       line0 <= rd_data;
        else if (do_pop) line0 <= line1;
        if (fill1)       line1 <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Bench for fetch_line_buffer: directed scenarios plus a randomized run checked
// against a model that tracks the set of buffered line addresses.
module tb_fetch_line_buffer;

  localparam int FB = 16;
  localparam int CW = $clog2(FB + 1);
  localparam int WB = FB * 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [63:0]   redirect_pc = '0;
  logic          out_valid;
  logic [63:0]   out_pc;
  logic [WB-1:0] out_bytes;
  logic [CW-1:0] consume = '0;
  logic          rd_reqcyc;
  logic [63:0]   rd_addr;
  logic          rd_respcyc = 1'b0;
  logic [511:0]  rd_data = '0;

  fetch_line_buffer #(.FETCH_BYTES(FB)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_bytes(out_bytes),
    .consume(consume),
    .rd_reqcyc(rd_reqcyc), .rd_addr(rd_addr),
    .rd_respcyc(rd_respcyc), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset && out_valid)
      assert (int'(consume) <= FB) else $error("illegal consume %0d", consume);

  int checks = 0;
  int passes = 0;

  // Reference model: fetch pc, buffered line addresses, outstanding read.
  logic [63:0]   m_pc, n_pc, m_pend_addr;
  logic [63:0]   m_lines[$], n_lines[$];
  bit            m_pend, m_pend_live, m_started;
  int            m_lat;
  bit            e_valid, e_reqcyc, d_resp, d_redir;
  logic [63:0]   e_addr;
  logic [WB-1:0] e_bytes;

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ a[47:40];
  endfunction

  function automatic logic [511:0] line_data(input logic [63:0] a);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[511-8*i -: 8] = mem_byte(a + 64'(i));
    return d;
  endfunction

  function automatic bit has_line(input logic [63:0] q[$], input logic [63:0] a);
    foreach (q[i]) if (q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [WB-1:0] seq_bytes(input int start, input logic [7:0] x);
    logic [WB-1:0] b;
    for (int i = 0; i < FB; i++) b[WB-1-8*i -: 8] = 8'(start + i) ^ x;
    return b;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_lines.delete(); m_pend = 0; m_pend_live = 0; m_started = 0; m_lat = 0;
  endtask

  // cons < 0 picks a random legal consume; resp_mode: -1 latency, 0 hold, 1 now.
  task automatic drive(input bit redir, input logic [63:0] rpc, input int cons, input int resp_mode);
    logic [63:0] base;
    int c;
    e_valid = has_line(m_lines, m_pc & ~64'h3F) && has_line(m_lines, (m_pc + 64'(FB - 1)) & ~64'h3F);
    c = (cons < 0) ? int'($urandom_range(FB, 0)) : cons;
    redirect_valid = redir;
    redirect_pc    = rpc;
    consume        = CW'(c);
    d_resp     = m_pend && (resp_mode == 1 || (resp_mode < 0 && m_lat == 0));
    d_redir    = redir;
    rd_respcyc = d_resp;
    rd_data    = d_resp ? line_data(m_pend_addr) : {16{$urandom()}};
    n_lines.delete();
    if (redir) n_pc = rpc;
    else       n_pc = e_valid ? m_pc + 64'(c) : m_pc;
    base = n_pc & ~64'h3F;
    if (!redir) foreach (m_lines[i]) if (m_lines[i] >= base) n_lines.push_back(m_lines[i]);
    e_reqcyc = m_started && !m_pend && !redir &&
               !(has_line(n_lines, base) && has_line(n_lines, base + 64'd64));
    e_addr   = m_pend ? m_pend_addr : (has_line(n_lines, base) ? base + 64'd64 : base);
    e_bytes  = '0;
    if (e_valid) for (int i = 0; i < FB; i++) e_bytes[WB-1-8*i -: 8] = mem_byte(m_pc + 64'(i));
    #1;
  endtask

  task automatic advance();
    logic [63:0] base;
    base = n_pc & ~64'h3F;
    if (d_resp) begin
      if (m_pend_live && !d_redir && (m_pend_addr == base || m_pend_addr == base + 64'd64) &&
          !has_line(n_lines, m_pend_addr))
        n_lines.push_back(m_pend_addr);
      m_pend = 0;
    end else if (m_pend) begin
      if (d_redir) m_pend_live = 0;
      if (m_lat > 0) m_lat--;
    end
    if (e_reqcyc) begin
      m_pend = 1; m_pend_addr = e_addr; m_pend_live = 1; m_lat = int'($urandom_range(3, 0));
    end
    m_pc = n_pc;
    m_lines = n_lines;
    m_started = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_bytes !== '0 || rd_reqcyc !== 1'b0 || rd_addr !== 64'h0)
      $display("FAIL reset_values: valid=%b pc=%h bytes=%h req=%b addr=%h, want all zero",
               out_valid, out_pc, out_bytes, rd_reqcyc, rd_addr);
    else passes++;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    drive(0, '0, 0, 0);
    checks++;
    if (rd_reqcyc !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL release_cycle: req=%b valid=%b, want 0 0", rd_reqcyc, out_valid);
    else passes++;
    advance();
  endtask

  task automatic test_first_line();
    drive(0, '0, 0, 0);
    checks++;
    if (rd_reqcyc !== 1'b1 || rd_addr !== 64'h0)
      $display("FAIL first_req: req=%b addr=%h, want 1 0", rd_reqcyc, rd_addr);
    else passes++;
    advance();
    drive(0, '0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL first_resp_cycle: valid=%b, want 0", out_valid);
    else passes++;
    advance();
    drive(0, '0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_bytes !== seq_bytes(0, 8'h00) ||
        rd_reqcyc !== 1'b1 || rd_addr !== 64'h40)
      $display("FAIL first_window: valid=%b pc=%h bytes=%h req=%b addr=%h, want 1 0 %h 1 40",
               out_valid, out_pc, out_bytes, rd_reqcyc, rd_addr, seq_bytes(0, 8'h00));
    else passes++;
    advance();
  endtask

  task automatic test_stream();
    drive(0, '0, 0, 1);
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(0, '0, 16, 0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(16 * k) || rd_reqcyc !== (k == 3) ||
          (k == 3 && rd_addr !== 64'h80))
        $display("FAIL stream_step%0d: valid=%b pc=%h req=%b addr=%h, want 1 %h %0d 80",
                 k, out_valid, out_pc, rd_reqcyc, rd_addr, 16 * k, k == 3);
      else passes++;
      advance();
    end
    drive(0, '0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_bytes !== seq_bytes(8'h40, 8'h00) || rd_addr !== 64'h80)
      $display("FAIL stream_pop: valid=%b pc=%h bytes=%h addr=%h, want 1 40 %h 80",
               out_valid, out_pc, out_bytes, rd_addr, seq_bytes(8'h40, 8'h00));
    else passes++;
    advance();
  endtask

  task automatic test_line_cross();
    drive(0, '0, 0, 1); advance();
    drive(1, 64'h3A, 0, 0);
    checks++;
    if (rd_reqcyc !== 1'b0) $display("FAIL cross_redirect_cycle: req=%b, want 0", rd_reqcyc);
    else passes++;
    advance();
    drive(0, '0, 0, 0);
    checks++;
    if (rd_reqcyc !== 1'b1 || rd_addr !== 64'h0 || out_valid !== 1'b0)
      $display("FAIL cross_req0: req=%b addr=%h valid=%b, want 1 0 0", rd_reqcyc, rd_addr, out_valid);
    else passes++;
    advance();
    drive(0, '0, 0, 1); advance();
    drive(0, '0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || rd_reqcyc !== 1'b1 || rd_addr !== 64'h40)
      $display("FAIL cross_half: valid=%b req=%b addr=%h, want 0 1 40", out_valid, rd_reqcyc, rd_addr);
    else passes++;
    advance();
    drive(0, '0, 0, 1); advance();
    drive(0, '0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h3A || out_bytes !== seq_bytes(8'h3A, 8'h00) || rd_reqcyc !== 1'b0)
      $display("FAIL cross_window: valid=%b pc=%h bytes=%h req=%b, want 1 3a %h 0",
               out_valid, out_pc, out_bytes, rd_reqcyc, seq_bytes(8'h3A, 8'h00));
    else passes++;
    advance();
  endtask

  task automatic test_redirect_discard();
    drive(1, 64'h0, 0, 0); advance();
    drive(0, '0, 0, 0); advance();
    drive(0, '0, 0, 1); advance();
    drive(0, '0, 0, 0);
    checks++;
    if (rd_reqcyc !== 1'b1 || rd_addr !== 64'h40)
      $display("FAIL discard_setup: req=%b addr=%h, want 1 40", rd_reqcyc, rd_addr);
    else passes++;
    advance();
    drive(1, 64'h1000, 0, 0); advance();
    for (int k = 0; k < 2; k++) begin
      drive(0, '0, 0, 0);
      checks++;
      if (rd_reqcyc !== 1'b0 || out_valid !== 1'b0 || rd_addr !== 64'h40)
        $display("FAIL discard_hold%0d: req=%b valid=%b addr=%h, want 0 0 40", k, rd_reqcyc, out_valid, rd_addr);
      else passes++;
      advance();
    end
    drive(0, '0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || rd_reqcyc !== 1'b0)
      $display("FAIL discard_resp: valid=%b req=%b, want 0 0", out_valid, rd_reqcyc);
    else passes++;
    advance();
    drive(0, '0, 0, 0);
    checks++;
    if (rd_reqcyc !== 1'b1 || rd_addr !== 64'h1000 || out_valid !== 1'b0)
      $display("FAIL discard_newreq: req=%b addr=%h valid=%b, want 1 1000 0", rd_reqcyc, rd_addr, out_valid);
    else passes++;
    advance();
    drive(0, '0, 0, 1); advance();
    drive(0, '0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h1000 || out_bytes !== seq_bytes(0, 8'h10) ||
        rd_reqcyc !== 1'b1 || rd_addr !== 64'h1040)
      $display("FAIL discard_window: valid=%b pc=%h bytes=%h req=%b addr=%h, want 1 1000 %h 1 1040",
               out_valid, out_pc, out_bytes, rd_reqcyc, rd_addr, seq_bytes(0, 8'h10));
    else passes++;
    advance();
  endtask

  task automatic test_redirect_on_resp();
    drive(1, 64'h2005, 0, 1); advance();
    drive(0, '0, 0, 0);
    checks++;
    if (rd_reqcyc !== 1'b1 || rd_addr !== 64'h2000 || out_valid !== 1'b0)
      $display("FAIL rsp_redirect_req: req=%b addr=%h valid=%b, want 1 2000 0", rd_reqcyc, rd_addr, out_valid);
    else passes++;
    advance();
    drive(0, '0, 0, 1); advance();
    drive(0, '0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h2005 || out_bytes !== seq_bytes(5, 8'h20))
      $display("FAIL rsp_redirect_window: valid=%b pc=%h bytes=%h, want 1 2005 %h",
               out_valid, out_pc, out_bytes, seq_bytes(5, 8'h20));
    else passes++;
    advance();
  endtask

  task automatic test_pop_fill();
    drive(1, 64'h30, 0, 0); advance();
    drive(0, '0, 0, 1); advance();
    drive(0, '0, 0, 0); advance();
    drive(0, '0, 0, 1); advance();
    drive(0, '0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h30 || rd_reqcyc !== 1'b1 || rd_addr !== 64'h40)
      $display("FAIL popfill_setup: valid=%b pc=%h req=%b addr=%h, want 1 30 1 40", out_valid, out_pc, rd_reqcyc, rd_addr);
    else passes++;
    advance();
    drive(0, '0, 16, 1); advance();
    drive(0, '0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_bytes !== seq_bytes(8'h40, 8'h00) ||
        rd_reqcyc !== 1'b1 || rd_addr !== 64'h80)
      $display("FAIL popfill_window: valid=%b pc=%h bytes=%h req=%b addr=%h, want 1 40 %h 1 80",
               out_valid, out_pc, out_bytes, rd_reqcyc, rd_addr, seq_bytes(8'h40, 8'h00));
    else passes++;
    advance();
  endtask

  task automatic test_random();
    bit          r;
    logic [63:0] rpc;
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(29, 0) == 0);
      rpc = 64'($urandom_range(4095, 0)) | (64'($urandom_range(1, 0)) << 40);
      drive(r, rpc, -1, -1);
      checks++;
      if (out_valid !== e_valid || out_pc !== m_pc || out_bytes !== e_bytes || rd_reqcyc !== e_reqcyc ||
          ((e_reqcyc || m_pend) && rd_addr !== e_addr))
        $display("FAIL random_cyc%0d: valid=%b pc=%h bytes=%h req=%b addr=%h, want %b %h %h %b %h",
                 n, out_valid, out_pc, out_bytes, rd_reqcyc, rd_addr, e_valid, m_pc, e_bytes, e_reqcyc, e_addr);
      else passes++;
      advance();
    end
  endtask

  task automatic test_async_reset();
    redirect_valid = 1'b0; rd_respcyc = 1'b0; consume = '0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'h0 || rd_reqcyc !== 1'b0 || rd_addr !== 64'h0)
      $display("FAIL async_reset: valid=%b pc=%h req=%b addr=%h, want 0 0 0 0", out_valid, out_pc, rd_reqcyc, rd_addr);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_stream();
    test_line_cross();
    test_redirect_discard();
    test_redirect_on_resp();
    test_pop_fill();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_line_buffer.md
Name: fetch_line_buffer

Overview:
- Instruction-fetch byte-window stage that sits downstream of the Muskbus line reader and also drives it.
- Issues sequential 64-byte line reads through the reader's reqcyc/addr/respcyc/data handshake.
- Keeps up to two consecutive lines and presents a FETCH_BYTES-wide byte window at the current fetch PC to the decoder.
- The decoder consumes a variable number of bytes per cycle; redirects (branches) flush the buffer and drop any read already in flight.

Parameters:
FETCH_BYTES, 16, width of the output window in bytes; legal range 1..64.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  64  new fetch byte address; any alignment
out_valid  output  1  window out_pc..out_pc+FETCH_BYTES-1 is fully buffered
out_pc  output  64  byte address of window byte 0
out_bytes  output  FETCH_BYTES*8  window; bits [0:7] hold the byte at out_pc, ascending addresses follow (MSB-first numbering, same as line data)
consume  input  $clog2(FETCH_BYTES+1)  bytes taken this cycle; honoured only when out_valid
rd_reqcyc  output  1  one-cycle line-read request to the reader
rd_addr  output  64  line address, 64-byte aligned; held stable from request until response
rd_respcyc  input  1  one-cycle pulse, line data valid
rd_data  input  512  line; bits [0:7] = byte at rd_addr

Behaviour:
- Reset (reset low, asynchronous assert):
  - pc=0; head line base H=0; v0=v1=0; fetch FSM in IDLE.
  - rd_reqcyc=0, rd_addr=0, out_valid=0, out_pc=0, out_bytes=0.
  - After reset releases, fetching starts at address 0.
- Line queue:
  - Entry0 holds line H; entry1 holds line H+64.
  - H is always pc with bits [5:0] cleared, except transiently during a pop (see Consume).
- Window:
  - out_pc=pc.
  - out_valid = v0 and (pc[5:0]+FETCH_BYTES <= 64 or v1). It is a combinational function of registers only; it does not depend on consume.
  - out_bytes is the contiguous byte slice of {entry0,entry1} starting at offset pc[5:0]. It is 0 when out_valid=0.
- Consume:
  - If out_valid and no redirect, pc <= pc+consume.
  - If pc[5:0]+consume >= 64, pop: entry0 <= entry1, v0 <= v1, v1 <= 0, H <= H+64.
  - consume > FETCH_BYTES is illegal; a bench assertion flags it.
  - consume is ignored while out_valid=0.
- Fetch FSM states: IDLE, WAIT, DISCARD.
  - IDLE: if not (v0 and v1) after this cycle's pop, drive rd_reqcyc=1 for exactly one cycle. rd_addr = H if entry0 empty, else H+64, evaluated on post-pop state. Record that address as A. Go to WAIT.
  - WAIT, on rd_respcyc: if A==H (current registered value, post-pop this cycle), write entry0 and set v0. Otherwise write entry1 and set v1. Go to IDLE. A response that matches neither line is dropped.
  - Pop and fill in the same cycle: the pop is applied first, then the fill lands in the slot matching A. There is no data loss.
  - The next request comes no earlier than the cycle after rd_respcyc, so the reader is back in idle.
  - DISCARD: on rd_respcyc, drop the data and go to IDLE.
- Redirect (highest priority, registered):
  - pc <= redirect_pc; H <= redirect_pc & ~63; v0=v1=0. Any consume in the same cycle is ignored.
  - In WAIT: go to DISCARD. If rd_respcyc arrives in the same cycle, drop it and go to IDLE.
  - In DISCARD: stay in DISCARD.
  - In IDLE: no request is issued in the redirect cycle; the first request, to the new H, goes out the next cycle.
- Latency:
  - Redirect at cycle T gives rd_reqcyc at T+1.
  - rd_respcyc at cycle R gives out_valid at R+1, provided the window fits in one line.
- Throughput: at most one outstanding read. rd_addr must not change while in WAIT or DISCARD.

Test Plan:
1. Reset, then release; reader returns line 0 with byte k = k -> rd_reqcyc at addr 0 one cycle after release. Next cycle: out_valid=1, out_pc=0, out_bytes = 00..0F. The block immediately requests addr 0x40.
2. Consume 16 each cycle with both lines filled -> out_pc steps 0x00,0x10,0x20,0x30. The pop at 0x40 moves entry1 into entry0, and a request for 0x80 issues.
3. Line crossing: redirect_pc=0x3A, only line 0 returned -> out_valid=0. After line 0x40 arrives: out_valid=1, with bytes 0x3A..0x49 spanning both lines.
4. Redirect to 0x1000 while WAIT for 0x40 -> DISCARD. The 0x40 data is dropped; the next request is addr 0x1000; out_valid stays 0 until that response.
5. Redirect in the same cycle as rd_respcyc -> data dropped, FSM goes to IDLE, and the request for the new line issues the following cycle.
6. Pop in the same cycle as the fill of entry1 (pc=0x30, consume=16, response for 0x40) -> next cycle: v0=1 with line 0x40, H=0x40, out_pc=0x40, out_valid=1.
